// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic multiplier: default operand width,
// controller state encoding and the full-run cycle count.
package dsc_pkg;

   localparam int unsigned DefaultWidth = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Enabled RUN cycles in a complete (non-early-exit) operation.
   function automatic int unsigned full_count(input int unsigned width);
      return 32'd1 << (2 * width);
   endfunction

   localparam int unsigned FullCount = full_count(DefaultWidth);

endpackage

// File: rtl/dsc_mul_counter.sv
// Free-running up-counter with synchronous reset, enable and a combinational wrap flag,
// used for both unary-stream generators and the product accumulator.
module counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             overflow
);

   logic [WIDTH-1:0] out_q, out_d;

   always_comb begin
      out_d = out_q;
      if (en) begin
         out_d = out_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out      = out_q;
   assign overflow = en && (out_q == '1);

endmodule

// File: rtl/dsc_mul.sv
// Deterministic stochastic multiplier: z accumulates AND of two clock-divided unary streams.
// Optional build macro DSC_MUL_EARLY_EXIT_EN finishes once the b stream has been exhausted.
module dsc_mul
   import dsc_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] z,
   output logic               ov
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             ov_q, ov_d;

   logic             step;
   logic [WIDTH-1:0] op_a, op_b;
   logic [WIDTH-1:0] ctr_a, ctr_b;
   logic             ctr_a_ovf, ctr_b_ovf;
   logic             sn_a, sn_b;
   logic             finish;
   logic             unused_acc_ovf;

   // Operands and advance strobe; on the IDLE->RUN edge the live inputs feed the comparators
   // because a_q/b_q are only being loaded on that same edge.
   always_comb begin
      step = 1'b0;
      op_a = a_q;
      op_b = b_q;
      a_d  = a_q;
      b_d  = b_q;
      unique case (state_q)
         StIdle: begin
            if (en) begin
               step = 1'b1;
               op_a = a;
               op_b = b;
               a_d  = a;
               b_d  = b;
            end
         end
         StRun:   step = en;
         StDone:  step = 1'b0;
         default: step = 1'b0;
      endcase
   end

   assign sn_a = (op_a > ctr_a);
   assign sn_b = (op_b > ctr_b);

   counter #(.WIDTH(WIDTH)) u_ctr_a (
      .clk      (clk),
      .rst      (rst),
      .en       (step),
      .out      (ctr_a),
      .overflow (ctr_a_ovf)
   );

   counter #(.WIDTH(WIDTH)) u_ctr_b (
      .clk      (clk),
      .rst      (rst),
      .en       (ctr_a_ovf),
      .out      (ctr_b),
      .overflow (ctr_b_ovf)
   );

   // Product never exceeds (2^WIDTH-1)^2, so the accumulator wrap flag is never raised.
   counter #(.WIDTH(2*WIDTH)) u_acc (
      .clk      (clk),
      .rst      (rst),
      .en       (step && sn_a && sn_b),
      .out      (z),
      .overflow (unused_acc_ovf)
   );

`ifdef DSC_MUL_EARLY_EXIT_EN
   logic [WIDTH-1:0] ctr_b_nxt;
   assign ctr_b_nxt = ctr_b + 1'b1;
   // A zero operand yields z=0 immediately; otherwise stop once every b row is counted.
   assign finish = ((state_q == StIdle) && ((op_a == '0) || (op_b == '0)))
                   || (ctr_a_ovf && (ctr_b_nxt == op_b))
                   || ctr_b_ovf;
`else
   assign finish = ctr_b_ovf;
`endif

   always_comb begin
      state_d = state_q;
      ov_d    = ov_q;
      if (step) begin
         if (finish) begin
            state_d = StDone;
            ov_d    = 1'b1;
         end else begin
            state_d = StRun;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ov_q    <= ov_d;
      end
   end

   assign ov = ov_q;

endmodule

// File: tb/tb_dsc_mul.sv
// Directed self-checking bench for dsc_mul; latency expectations follow DSC_MUL_EARLY_EXIT_EN.
module tb_dsc_mul;
   import dsc_pkg::*;

   localparam int unsigned W = DefaultWidth;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [W-1:0]   a, b;
   logic [2*W-1:0] z;
   logic           ov;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dsc_mul #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (a),
      .b   (b),
      .z   (z),
      .ov  (ov)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_lat(input int av, input int bv);
`ifdef DSC_MUL_EARLY_EXIT_EN
      return (av == 0 || bv == 0) ? 1 : 16 * bv;
`else
      return FullCount;
`endif
   endfunction

   task automatic step_edge();
      @(posedge clk);
      #1;
   endtask

   // Reset held with en=1 and nonzero operands to show rst wins.
   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b1;
      a   = 4'd9;
      b   = 4'd9;
      step_edge();
      check("rst_z", int'(z), 0);
      check("rst_ov", int'(ov), 0);
      rst = 1'b0;
      en  = 1'b0;
   endtask

   task automatic run_op(input int av, input int bv, input string tag);
      int lat;
      lat = 0;
      a   = W'(av);
      b   = W'(bv);
      en  = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         step_edge();
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         if (ov) begin
            lat = n;
            break;
         end
      end
      check({tag, "_lat"}, lat, exp_lat(av, bv));
      check({tag, "_z"}, int'(z), av * bv);
   endtask

   initial begin
      int ens;
      rst = 1'b1;
      en  = 1'b0;
      a   = '0;
      b   = '0;
      step_edge();
      check("init_z", int'(z), 0);
      check("init_ov", int'(ov), 0);
      rst = 1'b0;

      run_op(15, 15, "m15x15");
      for (int i = 0; i < 10; i++) begin
         en = 1'b1;
         a  = W'($urandom_range(0, 15));
         b  = W'($urandom_range(0, 15));
         step_edge();
         check("hold_z", int'(z), 225);
         check("hold_ov", int'(ov), 1);
      end

      do_reset();
      run_op(9, 6, "m9x6");
      do_reset();
      run_op(0, 7, "m0x7");
      do_reset();
      run_op(7, 0, "m7x0");
      do_reset();

      // Pause test: en on odd edges only, operands scrambled after every edge.
      a   = 4'd13;
      b   = 4'd11;
      ens = 0;
      for (int n = 1; n <= 700; n++) begin
         en = (n % 2 == 1);
         step_edge();
         if (en) ens++;
         a = W'($urandom_range(0, 15));
         b = W'($urandom_range(0, 15));
         if (ov) break;
      end
      check("pause_ens", ens, exp_lat(13, 11));
      check("pause_z", int'(z), 143);

      // Abort mid-run: after 100 edges of 12x12, six full rows of 12 plus 4 = 76.
      do_reset();
      a  = 4'd12;
      b  = 4'd12;
      en = 1'b1;
      repeat (100) step_edge();
      check("mid_z", int'(z), 76);
      check("mid_ov", int'(ov), 0);
      rst = 1'b1;
      step_edge();
      check("abort_z", int'(z), 0);
      check("abort_ov", int'(ov), 0);
      rst = 1'b0;
      en  = 1'b0;
      run_op(5, 3, "m5x3");

      rst = 1'b1;
      step_edge();
      check("done_rst_z", int'(z), 0);
      check("done_rst_ov", int'(ov), 0);
      rst = 1'b0;

      for (int i = 0; i < 40; i++) begin
         int av, bv;
         av = int'($urandom_range(0, 15));
         bv = int'($urandom_range(0, 15));
         do_reset();
         run_op(av, bv, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
